// File: rtl/counter_timer_high.sv
// High 32-bit word of the chained 64-bit counter/timer; runs standalone when chain=0.
// Optional build macro COUNTER_TIMER_HIGH_IRQ_STICKY_EN makes irq_out a sticky pending flag.
module counter_timer_high (
   input  logic        clkin,
   input  logic        resetn,
   input  logic        reg_cfg_we,
   input  logic [31:0] reg_cfg_di,
   output logic [31:0] reg_cfg_do,
   input  logic [3:0]  reg_val_we,
   input  logic [31:0] reg_val_di,
   output logic [31:0] reg_val_do,
   input  logic [3:0]  reg_dat_we,
   input  logic [31:0] reg_dat_di,
   output logic [31:0] reg_dat_do,
   input  logic        strobe,
   input  logic        is_offset,
   input  logic        stop_in,
   input  logic        enable_in,
   output logic        stop_out,
   output logic        enable_out,
   output logic        irq_out
);

   logic        enable_q, enable_d;
   logic        oneshot_q, oneshot_d;
   logic        updown_q, updown_d;
   logic        chain_q, chain_d;
   logic        irq_ena_q, irq_ena_d;
   logic [31:0] value_reset_q, value_reset_d;
   logic [31:0] value_cur_q, value_cur_d;
   logic        stop_out_q, stop_out_d;
   logic        irq_out_q, irq_out_d;
   logic        lastenable_q, lastenable_d;
   logic        stop_in_d_q, stop_in_d_d;
   logic        end_cond_d_q, end_cond_d_d;

   logic        loc_en;
   logic [31:0] term;
   logic [31:0] load_val;
   logic [31:0] cur_next;
   logic        at_term;
   logic        end_cond;
   logic        irq_set;
   logic        dat_write;

   always_comb begin
      enable_d      = enable_q;
      oneshot_d     = oneshot_q;
      updown_d      = updown_q;
      chain_d       = chain_q;
      irq_ena_d     = irq_ena_q;
      value_reset_d = value_reset_q;
      value_cur_d   = value_cur_q;
      stop_out_d    = stop_out_q;
      irq_out_d     = irq_out_q;
      end_cond_d_d  = end_cond_d_q;
      cur_next      = value_cur_q;

      loc_en       = chain_q ? (enable_q & enable_in) : enable_q;
      lastenable_d = loc_en;
      stop_in_d_d  = stop_in;
      dat_write    = |reg_dat_we;

      // With an offset low word the pair reaches the end one high count early.
      if (updown_q)
         term = (chain_q && is_offset) ? (value_reset_q - 32'd1) : value_reset_q;
      else
         term = 32'd0;
      load_val = updown_q ? 32'd0 : value_reset_q;
      at_term  = (value_cur_q == term);

      end_cond = chain_q ? (stop_out_q & stop_in) : stop_out_q;
      irq_set  = irq_ena_q & end_cond & ~end_cond_d_q;

      if (reg_cfg_we) begin
         enable_d  = reg_cfg_di[0];
         oneshot_d = reg_cfg_di[1];
         updown_d  = reg_cfg_di[2];
         chain_d   = reg_cfg_di[3];
         irq_ena_d = reg_cfg_di[4];
      end

      for (int b = 0; b < 4; b++) begin
         if (reg_val_we[b])
            value_reset_d[b*8 +: 8] = reg_val_di[b*8 +: 8];
      end

      if (dat_write) begin
         for (int b = 0; b < 4; b++) begin
            if (reg_dat_we[b])
               value_cur_d[b*8 +: 8] = reg_dat_di[b*8 +: 8];
         end
      end else if (!loc_en) begin
         end_cond_d_d = end_cond;
`ifndef COUNTER_TIMER_HIGH_IRQ_STICKY_EN
         irq_out_d    = 1'b0;
`endif
      end else begin
         end_cond_d_d = end_cond;
`ifndef COUNTER_TIMER_HIGH_IRQ_STICKY_EN
         irq_out_d    = irq_set;
`endif
         if (!lastenable_q) begin
            value_cur_d = load_val;
            stop_out_d  = 1'b0;
         end else if (at_term) begin
            // At the end count events are ignored; chained reload waits for the low word to wrap.
            if (oneshot_q)
               stop_out_d = 1'b1;
            else if (!chain_q || (stop_in_d_q && !stop_in)) begin
               value_cur_d = load_val;
               stop_out_d  = 1'b0;
            end else
               stop_out_d = 1'b1;
         end else begin
            if (!chain_q || strobe)
               cur_next = updown_q ? (value_cur_q + 32'd1) : (value_cur_q - 32'd1);
            value_cur_d = cur_next;
            stop_out_d  = (cur_next == term);
         end
      end

`ifdef COUNTER_TIMER_HIGH_IRQ_STICKY_EN
      // Clear first so a simultaneous set wins.
      if (reg_cfg_we && reg_cfg_di[5])
         irq_out_d = 1'b0;
      if (!dat_write && irq_set)
         irq_out_d = 1'b1;
`endif
   end

   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         enable_q      <= 1'b0;
         oneshot_q     <= 1'b0;
         updown_q      <= 1'b0;
         chain_q       <= 1'b0;
         irq_ena_q     <= 1'b0;
         value_reset_q <= 32'd0;
         value_cur_q   <= 32'd0;
         stop_out_q    <= 1'b0;
         irq_out_q     <= 1'b0;
         lastenable_q  <= 1'b0;
         stop_in_d_q   <= 1'b0;
         end_cond_d_q  <= 1'b0;
      end else begin
         enable_q      <= enable_d;
         oneshot_q     <= oneshot_d;
         updown_q      <= updown_d;
         chain_q       <= chain_d;
         irq_ena_q     <= irq_ena_d;
         value_reset_q <= value_reset_d;
         value_cur_q   <= value_cur_d;
         stop_out_q    <= stop_out_d;
         irq_out_q     <= irq_out_d;
         lastenable_q  <= lastenable_d;
         stop_in_d_q   <= stop_in_d_d;
         end_cond_d_q  <= end_cond_d_d;
      end
   end

`ifdef COUNTER_TIMER_HIGH_IRQ_STICKY_EN
   assign reg_cfg_do = {26'd0, irq_out_q, irq_ena_q, chain_q, updown_q, oneshot_q, enable_q};
`else
   assign reg_cfg_do = {27'd0, irq_ena_q, chain_q, updown_q, oneshot_q, enable_q};
`endif
   assign reg_val_do = value_reset_q;
   assign reg_dat_do = value_cur_q;
   assign stop_out   = stop_out_q;
   assign enable_out = enable_q;
   assign irq_out    = irq_out_q;

endmodule

// File: tb/tb_counter_timer_high.sv
// Directed bench for counter_timer_high: standalone/chained counting, write priority, reset.
module tb_counter_timer_high;

   logic        clkin = 1'b0;
   logic        resetn = 1'b0;
   logic        reg_cfg_we = 1'b0;
   logic [31:0] reg_cfg_di = 32'd0;
   logic [31:0] reg_cfg_do;
   logic [3:0]  reg_val_we = 4'd0;
   logic [31:0] reg_val_di = 32'd0;
   logic [31:0] reg_val_do;
   logic [3:0]  reg_dat_we = 4'd0;
   logic [31:0] reg_dat_di = 32'd0;
   logic [31:0] reg_dat_do;
   logic        strobe = 1'b0;
   logic        is_offset = 1'b0;
   logic        stop_in = 1'b0;
   logic        enable_in = 1'b0;
   logic        stop_out;
   logic        enable_out;
   logic        irq_out;

   int tests_run = 0;
   int tests_failed = 0;

`ifdef COUNTER_TIMER_HIGH_IRQ_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   counter_timer_high dut (
      .clkin(clkin), .resetn(resetn),
      .reg_cfg_we(reg_cfg_we), .reg_cfg_di(reg_cfg_di), .reg_cfg_do(reg_cfg_do),
      .reg_val_we(reg_val_we), .reg_val_di(reg_val_di), .reg_val_do(reg_val_do),
      .reg_dat_we(reg_dat_we), .reg_dat_di(reg_dat_di), .reg_dat_do(reg_dat_do),
      .strobe(strobe), .is_offset(is_offset), .stop_in(stop_in), .enable_in(enable_in),
      .stop_out(stop_out), .enable_out(enable_out), .irq_out(irq_out)
   );

   always #5 clkin = ~clkin;

   task automatic step();
      @(posedge clkin);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic write_cfg(input logic [31:0] v);
      reg_cfg_we = 1'b1; reg_cfg_di = v;
      step();
      reg_cfg_we = 1'b0; reg_cfg_di = 32'd0;
   endtask

   task automatic write_val(input logic [3:0] we, input logic [31:0] v);
      reg_val_we = we; reg_val_di = v;
      step();
      reg_val_we = 4'd0; reg_val_di = 32'd0;
   endtask

   task automatic write_dat(input logic [3:0] we, input logic [31:0] v);
      reg_dat_we = we; reg_dat_di = v;
      step();
      reg_dat_we = 4'd0; reg_dat_di = 32'd0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      #2;
      resetn = 1'b1;
      step();
   endtask

   initial begin
      strobe = 1'b0; is_offset = 1'b0; stop_in = 1'b0; enable_in = 1'b0;
      #12;
      check("rst_cfg", reg_cfg_do, 32'd0);
      check("rst_dat", reg_dat_do, 32'd0);
      check("rst_stop", {31'd0, stop_out}, 32'd0);
      resetn = 1'b1;
      step();

      // Standalone down, continuous, irq enabled
      write_val(4'hF, 32'd3);
      check("down_val", reg_val_do, 32'd3);
      write_cfg(32'h11);
      check("down_cfg", reg_cfg_do, 32'h11);
      check("down_enout", {31'd0, enable_out}, 32'd1);
      step(); check("down_c3", reg_dat_do, 32'd3);
      step(); check("down_c2", reg_dat_do, 32'd2);
      step(); check("down_c1", reg_dat_do, 32'd1);
      step();
      check("down_c0", reg_dat_do, 32'd0);
      check("down_stop0", {31'd0, stop_out}, 32'd1);
      check("down_irq_pre", {31'd0, irq_out}, 32'd0);
      step();
      check("down_reload", reg_dat_do, 32'd3);
      check("down_stop_clr", {31'd0, stop_out}, 32'd0);
      check("down_irq", {31'd0, irq_out}, 32'd1);
      step();
      check("down_c2b", reg_dat_do, 32'd2);
      check("down_irq_after", {31'd0, irq_out}, {31'd0, STICKY});
      check("down_cfg_pend", reg_cfg_do, STICKY ? 32'h31 : 32'h11);
`ifdef COUNTER_TIMER_HIGH_IRQ_STICKY_EN
      write_cfg(32'h31);
      check("sticky_clear", {31'd0, irq_out}, 32'd0);
      check("sticky_cfg", reg_cfg_do, 32'h11);
`endif

      // Asynchronous reset mid-count
      #2;
      resetn = 1'b0;
      #1;
      check("arst_dat", reg_dat_do, 32'd0);
      check("arst_val", reg_val_do, 32'd0);
      check("arst_cfg", reg_cfg_do, 32'd0);
      check("arst_outs", {29'd0, stop_out, enable_out, irq_out}, 32'd0);
      resetn = 1'b1;
      step();

      // Standalone up oneshot
      write_val(4'hF, 32'd2);
      write_cfg(32'h07);
      step(); check("os_c0", reg_dat_do, 32'd0);
      step(); check("os_c1", reg_dat_do, 32'd1);
      step();
      check("os_c2", reg_dat_do, 32'd2);
      check("os_stop", {31'd0, stop_out}, 32'd1);
      step(); step();
      check("os_hold", reg_dat_do, 32'd2);
      check("os_stop_hold", {31'd0, stop_out}, 32'd1);
      check("os_noirq", {31'd0, irq_out}, 32'd0);

      // Chained up with offset low word: terminal is value-1
      do_reset();
      enable_in = 1'b1; is_offset = 1'b1;
      write_val(4'hF, 32'd5);
      write_cfg(32'h0D);
      step(); check("ch_start", reg_dat_do, 32'd0);
      step(); check("ch_nostrobe", reg_dat_do, 32'd0);
      strobe = 1'b1;
      step(); check("ch_c1", reg_dat_do, 32'd1);
      step(); step(); step();
      check("ch_c4", reg_dat_do, 32'd4);
      check("ch_stop", {31'd0, stop_out}, 32'd1);
      step();
      check("ch_ignore", reg_dat_do, 32'd4);
      strobe = 1'b0;
      enable_in = 1'b0;
      step(); step();
      check("ch_frozen", reg_dat_do, 32'd4);
      enable_in = 1'b1;
      step();
      check("ch_restart", reg_dat_do, 32'd0);
      strobe = 1'b1;
      step(); step(); step(); step();
      check("ch_c4b", reg_dat_do, 32'd4);
      strobe = 1'b0;
      stop_in = 1'b1;
      step();
      check("ch_wait_wrap", reg_dat_do, 32'd4);
      stop_in = 1'b0;
      step();
      check("ch_reload", reg_dat_do, 32'd0);
      check("ch_reload_stop", {31'd0, stop_out}, 32'd0);

      // Chained oneshot down
      do_reset();
      enable_in = 1'b1; is_offset = 1'b0; stop_in = 1'b0;
      write_val(4'hF, 32'd1);
      write_cfg(32'h0B);
      step(); check("cos_load", reg_dat_do, 32'd1);
      strobe = 1'b1;
      step();
      check("cos_c0", reg_dat_do, 32'd0);
      check("cos_stop", {31'd0, stop_out}, 32'd1);
      stop_in = 1'b1;
      step(); step(); step();
      check("cos_hold", reg_dat_do, 32'd0);
      check("cos_stop_hold", {31'd0, stop_out}, 32'd1);
      check("cos_noirq", {31'd0, irq_out}, 32'd0);
      strobe = 1'b0; stop_in = 1'b0;

      // Write priority, byte lanes, wrap, freeze/restart
      do_reset();
      write_val(4'hF, 32'h0000_0100);
      write_val(4'b0100, 32'h00FF_0000);
      check("val_lane", reg_val_do, 32'h00FF_0100);
      write_cfg(32'h05);
      step(); step(); step();
      check("wp_pre", reg_dat_do, 32'd2);
      write_dat(4'b0001, 32'h0000_00AA);
      check("wp_write", reg_dat_do, 32'h0000_00AA);
      step();
      check("wp_resume", reg_dat_do, 32'h0000_00AB);
      write_cfg(32'h04);
      check("dis_last", reg_dat_do, 32'h0000_00AC);
      step(); step();
      check("dis_freeze", reg_dat_do, 32'h0000_00AC);
      check("dis_enout", {31'd0, enable_out}, 32'd0);
      write_cfg(32'h05);
      step();
      check("reen_restart", reg_dat_do, 32'd0);
      write_dat(4'hF, 32'hFFFF_FFFF);
      check("wrap_pre", reg_dat_do, 32'hFFFF_FFFF);
      step();
      check("wrap_up", reg_dat_do, 32'd0);
      check("wrap_stop", {31'd0, stop_out}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/counter_timer_high.md
Name: counter_timer_high

Overview:
- High 32-bit word of the 64-bit chained counter/timer.
- Pairs with the low-word counter: consumes the low word's `strobe`, `is_offset`, `stop_out` and `enable_out`; drives the low word's `stop_in` and `enable_in`.
- With chain=0 it runs as an independent 32-bit counter/timer.
- Register interface matches the low word (cfg/value/data), so the same Wishbone wrapper style applies.

Parameters:
- none (all behaviour is runtime-configured through `reg_cfg`)

Ports:
- clkin  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- reg_cfg_we  in  1  cfg write enable
- reg_cfg_di  in  32  cfg write data
- reg_cfg_do  out  32  cfg readback
- reg_val_we  in  4  terminal/reload value byte-lane write enables
- reg_val_di  in  32  value write data
- reg_val_do  out  32  value readback
- reg_dat_we  in  4  current-count byte-lane write enables
- reg_dat_di  in  32  count write data
- reg_dat_do  out  32  current count
- strobe  in  1  low word rollover strobe (one count event per high cycle)
- is_offset  in  1  low word counting up with reload value 0
- stop_in  in  1  low word stop flag
- enable_in  in  1  low word enable
- stop_out  out  1  high word at terminal (to low `stop_in`)
- enable_out  out  1  equals cfg enable (to low `enable_in`)
- irq_out  out  1  interrupt

Behaviour:
- **Reset values:** all cfg bits, value_reset, value_cur, stop_out, irq_out, lastenable and stop_in_d are 0.
- **cfg bits:** [0] enable, [1] oneshot, [2] updown (1=up), [3] chain, [4] irq_ena. `reg_cfg_do` = {27'd0, irq_ena, chain, updown, oneshot, enable}.
- **Register writes:** `reg_val_we` / `reg_dat_we` write their byte lanes independently.
- **Write priority:** any `reg_dat_we` bit set has priority over counting that cycle; stop_out and irq_out hold their values.
- **Local enable:** loc_en = chain ? (enable & enable_in) : enable. enable_out = enable (combinational).
- **Terminal T:**
  - up and chain and is_offset: T = value_reset - 1, mod 2^32.
  - otherwise up: T = value_reset.
  - down: T = 0.
- **Start (loc_en=1, lastenable=0):** up loads value_cur=0; down loads value_cur=value_reset. stop_out <= 0.
- **Count event:**
  - chain=0: every enabled cycle.
  - chain=1: enabled cycles with strobe=1.
  - Each event is ±1 with 32-bit wrap (0xFFFFFFFF+1=0, 0-1=0xFFFFFFFF).
- **stop_out:** registered. Each enabled cycle, stop_out <= (value_cur_next == T).
- **Standalone (chain=0) at value_cur == T:**
  - oneshot=1: hold value and stop_out=1.
  - oneshot=0: next cycle reload (up: 0, down: value_reset) and stop_out <= 0.
- **Chained (chain=1) at value_cur == T:**
  - Count events are ignored.
  - oneshot=1: hold with stop_out=1.
  - oneshot=0: reload when stop_in_d=1 and stop_in=0 (low word has wrapped), and stop_out <= 0.
  - stop_in_d is stop_in delayed one cycle.
- **Disabled (loc_en=0):** value_cur holds; stop_out holds; irq_out <= 0.
- **IRQ:** one-cycle pulse the cycle after the end condition first becomes true, only when irq_ena=1.
  - chain=0: rising edge of stop_out.
  - chain=1: rising edge of (stop_out & stop_in).
  - Never asserted on two consecutive cycles.
- **Mid-operation changes:**
  - value_reset written mid-count takes effect at the next compare; no reload.
  - A cfg write clearing enable freezes the count; re-enabling restarts from the load value.
- **Reset** asserted at any time forces the reset values immediately (asynchronous).

Optional Feature:
- Macro: COUNTER_TIMER_HIGH_IRQ_STICKY_EN.
- **Defined:**
  - irq_out latches 1 on the IRQ condition and stays 1 until a cfg write with reg_cfg_di[5]=1 clears it.
  - A set and a clear in the same cycle leave irq_out set.
  - `reg_cfg_do[5]` reads the pending flag.
  - The disabled-counter forcing of irq_out to 0 does not apply.
- **Undefined:** one-cycle pulse as specified above; reg_cfg_do[5]=0; reg_cfg_di[5] ignored.

Test Plan:
- **Reset:** assert resetn=0 mid-count -> all outputs and registers 0 immediately; enable_out=0.
- **Standalone down, continuous:** chain=0, value=3, cfg=0x11 -> count 3,2,1,0,3...; stop_out high while count=0; irq_out one pulse one cycle after each stop_out rise.
- **Standalone up, oneshot:** value=2, cfg=0x07 -> count 0,1,2 then holds at 2; stop_out stays 1.
- **Chained up with is_offset=1:** value=5, cfg=0x0D -> T=4; count advances only on strobe pulses; stop_out=1 at count 4.
  - Then stop_in 1->0 -> count reloads to 0.
- **Chained oneshot down:** value=1, cfg=0x0B, strobe once -> count 0 and stop_out=1.
  - Then stop_in=1 with further strobes -> count holds 0; irq_out=0 since irq_ena=0.
- **Write priority:** `reg_dat_we`=4'b0001 with data 0xAA on an enabled cycle -> value_cur[7:0]=0xAA, no count that cycle.
  - With COUNTER_TIMER_HIGH_IRQ_STICKY_EN: irq_out holds after the pulse until a cfg write with bit5=1 clears it.
